// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter that shares a 4:1 single-bit data mux.
//            Define ARB_QUANTUM_EN to cap a grant at QUANTUM cycles under contention.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int QUANTUM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       dout,
  output logic       dout_valid,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       busy_q, busy_d;
  logic       dout_q, dvalid_q;
  logic [3:0] others_w;
  logic [2:0] win_w;
  logic       release_w;

`ifdef ARB_QUANTUM_EN
  localparam logic [7:0] QMAX = 8'(QUANTUM - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  localparam logic [7:0] QUANTUM_UNUSED = 8'(QUANTUM);
  logic unused_quantum;
  assign unused_quantum = ^QUANTUM_UNUSED;
`endif

  // Returns {found, index}: first set bit of r scanning p, p+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    others_w  = req & ~(4'b0001 << sel_q);
    release_w = ~req[sel_q];
`ifdef ARB_QUANTUM_EN
    if (cnt_q == QMAX && |others_w) release_w = 1'b1;
`endif
    win_w = (state_q == GRANT) ? pick(others_w, sel_q + 2'd1) : pick(req, ptr_q);

    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
`ifdef ARB_QUANTUM_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_w[2]) begin
          gnt_d   = 4'b0001 << win_w[1:0];
          sel_d   = win_w[1:0];
          state_d = GRANT;
          busy_d  = 1'b1;
`ifdef ARB_QUANTUM_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (release_w) begin
          ptr_d = sel_q + 2'd1;
          if (win_w[2]) begin
            // Back-to-back handover: no idle cycle between grants.
            gnt_d = 4'b0001 << win_w[1:0];
            sel_d = win_w[1:0];
`ifdef ARB_QUANTUM_EN
            cnt_d = 8'd0;
`endif
          end else begin
            gnt_d   = 4'b0000;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
`ifdef ARB_QUANTUM_EN
        else if (cnt_q != QMAX) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'b00;
      ptr_q    <= 2'b00;
      busy_q   <= 1'b0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
`ifdef ARB_QUANTUM_EN
      cnt_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      dvalid_q <= |gnt_q;
      if (|gnt_q) dout_q <= din[sel_q];
`ifdef ARB_QUANTUM_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dvalid_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Directed self-checking bench for mux4_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       dout;
  logic       dout_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.QUANTUM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] d);
    req = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  // Expected vector layout: {gnt, sel, dout, dout_valid, busy}.
  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {gnt, sel, dout, dout_valid, busy};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (gnt === exp) else begin
      failures++;
      $error("FAIL %s observed_gnt=%b required_gnt=%b", tag, gnt, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    din = 4'b0000;

    // Reset held for three cycles.
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    chk("reset", {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;

    // Single requester 1 with data 1,0,1,1.
    cyc(4'b0010, 4'b0000);
    chk("single_gnt", {4'b0010, 2'b01, 1'b0, 1'b0, 1'b1});
    cyc(4'b0010, 4'b0010);
    chk("single_d1", {4'b0010, 2'b01, 1'b1, 1'b1, 1'b1});
    cyc(4'b0010, 4'b0000);
    chk("single_d0", {4'b0010, 2'b01, 1'b0, 1'b1, 1'b1});
    cyc(4'b0010, 4'b0010);
    chk("single_d1b", {4'b0010, 2'b01, 1'b1, 1'b1, 1'b1});
    cyc(4'b0000, 4'b0010);
    chk("single_release", {4'b0000, 2'b01, 1'b1, 1'b1, 1'b0});
    cyc(4'b0000, 4'b0000);
    chk("single_idle", {4'b0000, 2'b01, 1'b1, 1'b0, 1'b0});

    // Fresh reset so the pointer starts at 0, then rotate through all four.
    rst = 1'b1;
    cyc(4'b0000, 4'b0000);
    rst = 1'b0;
    cyc(4'b1111, 4'b1010);
    chk("rot_g0a", {4'b0001, 2'b00, 1'b0, 1'b0, 1'b1});
    cyc(4'b1111, 4'b1010);
    chk("rot_g0b", {4'b0001, 2'b00, 1'b0, 1'b1, 1'b1});
    cyc(4'b1110, 4'b1010);
    chk("rot_g1a", {4'b0010, 2'b01, 1'b0, 1'b1, 1'b1});
    cyc(4'b1110, 4'b1010);
    chk("rot_g1b", {4'b0010, 2'b01, 1'b1, 1'b1, 1'b1});
    cyc(4'b1100, 4'b1010);
    chk("rot_g2a", {4'b0100, 2'b10, 1'b1, 1'b1, 1'b1});
    cyc(4'b1100, 4'b1010);
    chk("rot_g2b", {4'b0100, 2'b10, 1'b0, 1'b1, 1'b1});

    // Wrap-around: last grant was 2, so 3 beats 0.
    cyc(4'b1001, 4'b1010);
    chk("wrap_g3a", {4'b1000, 2'b11, 1'b0, 1'b1, 1'b1});
    cyc(4'b1001, 4'b1010);
    chk("wrap_g3b", {4'b1000, 2'b11, 1'b1, 1'b1, 1'b1});
    cyc(4'b0001, 4'b1010);
    chk("wrap_g0", {4'b0001, 2'b00, 1'b1, 1'b1, 1'b1});
    cyc(4'b0000, 4'b1010);
    chk("wrap_release", {4'b0000, 2'b00, 1'b0, 1'b1, 1'b0});
    cyc(4'b0000, 4'b1010);
    chk("wrap_idle", {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0});

    // Withdrawn request: req[2] pulses while requester 0 holds the grant.
    cyc(4'b0001, 4'b0000);
    chk_gnt("wd_g0", 4'b0001);
    cyc(4'b0101, 4'b0000);
    chk_gnt("wd_pulse", 4'b0001);
    cyc(4'b0001, 4'b0000);
    chk_gnt("wd_hold", 4'b0001);
    cyc(4'b0000, 4'b0000);
    chk_gnt("wd_release", 4'b0000);
    cyc(4'b0000, 4'b0000);
    chk_gnt("wd_idle", 4'b0000);

    // Asynchronous reset in the middle of a grant.
    cyc(4'b0010, 4'b0010);
    chk("async_pre", {4'b0010, 2'b01, 1'b0, 1'b0, 1'b1});
    cyc(4'b0010, 4'b0010);
    rst = 1'b1;
    #2;
    chk("async_clear", {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0});
    cyc(4'b0000, 4'b0000);
    rst = 1'b0;

`ifdef ARB_QUANTUM_EN
    // QUANTUM=4: two contenders alternate every four cycles.
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0011, 4'b0000);
      chk_gnt("q_first0", 4'b0001);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0011, 4'b0000);
      chk_gnt("q_then1", 4'b0010);
    end
    cyc(4'b0011, 4'b0000);
    chk_gnt("q_back0", 4'b0001);
    // Alone, requester 0 keeps the grant past the quantum.
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0001, 4'b0000);
      chk_gnt("q_alone", 4'b0001);
    end
`else
    // Without the quantum a grant lasts as long as the request.
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0011, 4'b0000);
      chk_gnt("noq_hold", 4'b0001);
    end
    cyc(4'b0010, 4'b0000);
    chk_gnt("noq_handover", 4'b0010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
